// File: rtl/traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_fsm
// Brief    : Intersection phase controller. Steps an eight-phase ring on the
//            1-second tick, skips left-turn arrows nobody asked for, and
//            drains the junction to all-red on an emergency override.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_fsm #(
  parameter int T_GREEN  = 8,   // dwell (ticks) of through-green phases 0 and 4, 1..255
  parameter int T_YELLOW = 3,   // dwell (ticks) of yellow phases 1 and 5, 1..255
  parameter int T_ALLRED = 2,   // dwell (ticks) of all-red phases 2 and 6, 1..255
  parameter int T_LEFT   = 5    // dwell (ticks) of left-arrow phases 3 and 7, 1..255
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       emergency,
  input  logic       left_req_ns,
  input  logic       left_req_ew,
  output logic [2:0] state,
  output logic [7:0] remaining,
  output logic       state_change,
  output logic       emergency_active
);

  // Phase codes are fixed by the LED datapath; do not renumber.
  typedef enum logic [2:0] {
    PH_NS_GREEN  = 3'd0,
    PH_NS_YELLOW = 3'd1,
    PH_NS_ALLRED = 3'd2,
    PH_EW_LEFT   = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5,
    PH_EW_ALLRED = 3'd6,
    PH_NS_LEFT   = 3'd7
  } phase_e;

  localparam logic [7:0] c_green  = 8'(T_GREEN);
  localparam logic [7:0] c_yellow = 8'(T_YELLOW);
  localparam logic [7:0] c_allred = 8'(T_ALLRED);
  localparam logic [7:0] c_left   = 8'(T_LEFT);

  phase_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic       state_change_q, state_change_d;
  logic       em_active_q, em_active_d;
  logic       left_ns_q, left_ns_d;
  logic       left_ew_q, left_ew_d;

  logic       go_phase;      // a green or left-arrow phase: emergency cuts it short
  logic       allred_phase;  // phases 2 and 6: where an emergency parks the junction

  // Dwell length loaded on entry to a phase.
  function automatic logic [7:0] dwell(input phase_e p);
    logic [7:0] d;
    d = c_allred;
    case (p)
      PH_NS_GREEN, PH_EW_GREEN:   d = c_green;
      PH_NS_YELLOW, PH_EW_YELLOW: d = c_yellow;
      PH_NS_ALLRED, PH_EW_ALLRED: d = c_allred;
      PH_EW_LEFT, PH_NS_LEFT:     d = c_left;
      default:                    d = c_allred;
    endcase
    return d;
  endfunction

  // Normal ring successor; the all-red phases pick the left arrow only if requested.
  function automatic phase_e next_phase(input phase_e cur, input logic ns_pend,
                                        input logic ew_pend);
    phase_e n;
    n = cur;
    case (cur)
      PH_NS_GREEN:  n = PH_NS_YELLOW;
      PH_NS_YELLOW: n = PH_NS_ALLRED;
      PH_NS_ALLRED: n = ew_pend ? PH_EW_LEFT : PH_EW_GREEN;
      PH_EW_LEFT:   n = PH_EW_GREEN;
      PH_EW_GREEN:  n = PH_EW_YELLOW;
      PH_EW_YELLOW: n = PH_EW_ALLRED;
      PH_EW_ALLRED: n = ns_pend ? PH_NS_LEFT : PH_NS_GREEN;
      PH_NS_LEFT:   n = PH_NS_GREEN;
      default:      n = PH_EW_ALLRED;
    endcase
    return n;
  endfunction

  assign go_phase     = (state_q == PH_NS_GREEN) || (state_q == PH_NS_LEFT) ||
                        (state_q == PH_EW_LEFT)  || (state_q == PH_EW_GREEN);
  assign allred_phase = (state_q == PH_NS_ALLRED) || (state_q == PH_EW_ALLRED);

  // Next-state: emergency first, then the release reload, then tick-driven dwell.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    em_active_d = em_active_q | emergency;
    left_ns_d   = left_ns_q | left_req_ns;
    left_ew_d   = left_ew_q | left_req_ew;

    if (emergency && go_phase) begin
      // Cut the green/arrow short into the yellow of the same approach.
      state_d     = ((state_q == PH_NS_GREEN) || (state_q == PH_NS_LEFT)) ?
                    PH_NS_YELLOW : PH_EW_YELLOW;
      remaining_d = c_yellow;
    end else if (emergency && allred_phase) begin
      // Park in all-red; the dwell is frozen at its full value.
      remaining_d = c_allred;
    end else if (allred_phase && em_active_q) begin
      // Override released: give a fresh all-red before the ring resumes.
      remaining_d = c_allred;
      em_active_d = 1'b0;
    end else if (tick) begin
      if (remaining_q > 8'd1) begin
        remaining_d = remaining_q - 8'd1;
      end else begin
        state_d     = next_phase(state_q, left_ns_q, left_ew_q);
        remaining_d = dwell(state_d);
      end
    end

    // Entering a left phase serves its request; the clear beats a same-cycle request.
    if ((state_d == PH_EW_LEFT) && (state_q != PH_EW_LEFT)) left_ew_d = 1'b0;
    if ((state_d == PH_NS_LEFT) && (state_q != PH_NS_LEFT)) left_ns_d = 1'b0;

    state_change_d = (state_d != state_q);
  end

  // State and registered outputs; asynchronous reset parks the junction in all-red.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= PH_EW_ALLRED;
      remaining_q    <= c_allred;
      state_change_q <= 1'b0;
      em_active_q    <= 1'b0;
      left_ns_q      <= 1'b0;
      left_ew_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      state_change_q <= state_change_d;
      em_active_q    <= em_active_d;
      left_ns_q      <= left_ns_d;
      left_ew_q      <= left_ew_d;
    end
  end

  assign state            = state_q;
  assign remaining        = remaining_q;
  assign state_change     = state_change_q;
  assign emergency_active = em_active_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_fsm
// Brief    : Self-checking bench for traffic_phase_fsm: directed scenarios and
//            randomized stimulus compared against a behavioural phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_fsm;

  localparam int G = 3;
  localparam int Y = 2;
  localparam int R = 1;
  localparam int L = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       tick = 1'b0;
  logic       emergency = 1'b0;
  logic       left_req_ns = 1'b0;
  logic       left_req_ew = 1'b0;
  logic [2:0] state;
  logic [7:0] remaining;
  logic       state_change;
  logic       emergency_active;

  traffic_phase_fsm #(
    .T_GREEN (G),
    .T_YELLOW(Y),
    .T_ALLRED(R),
    .T_LEFT  (L)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .tick            (tick),
    .emergency       (emergency),
    .left_req_ns     (left_req_ns),
    .left_req_ew     (left_req_ew),
    .state           (state),
    .remaining       (remaining),
    .state_change    (state_change),
    .emergency_active(emergency_active)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase number, ticks left, pending left requests.
  int dwell_tab[8];
  int m_phase;
  int m_rem;
  bit m_sc;
  bit m_act;
  bit m_lns;
  bit m_lew;

  int cyc;
  int last_state;
  int phase_log[$];
  int exp_log[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 6; m_rem = R; m_sc = 0; m_act = 0; m_lns = 0; m_lew = 0;
  endtask

  // One clock edge of the intersection rules.
  task automatic m_step(input bit t, input bit em, input bit rns, input bit rew);
    int np, nr;
    bit go, red, nact;
    np   = m_phase;
    nr   = m_rem;
    nact = m_act || em;
    go   = (m_phase == 0) || (m_phase == 3) || (m_phase == 4) || (m_phase == 7);
    red  = (m_phase == 2) || (m_phase == 6);
    if (em && go) begin
      np = (m_phase == 0 || m_phase == 7) ? 1 : 5;
      nr = Y;
    end else if (em && red) begin
      nr = R;
    end else if (red && m_act) begin
      nr = R;
      nact = 0;
    end else if (t) begin
      if (m_rem > 1) nr = m_rem - 1;
      else begin
        if (m_phase == 2)      np = m_lew ? 3 : 4;
        else if (m_phase == 6) np = m_lns ? 7 : 0;
        else                   np = (m_phase + 1) % 8;
        nr = dwell_tab[np];
      end
    end
    m_lns   = (m_lns || rns) && !(np == 7 && m_phase != 7);
    m_lew   = (m_lew || rew) && !(np == 3 && m_phase != 3);
    m_sc    = (np != m_phase);
    m_phase = np;
    m_rem   = nr;
    m_act   = nact;
  endtask

  // Drive inputs on the falling edge, let the DUT clock them, compare after.
  task automatic cycle(input bit t, input bit em, input bit rns, input bit rew);
    @(negedge clock);
    tick = t; emergency = em; left_req_ns = rns; left_req_ew = rew;
    @(posedge clock);
    m_step(t, em, rns, rew);
    #1;
    chk("state", int'(state), m_phase);
    chk("remaining", int'(remaining), m_rem);
    chk("state_change", int'(state_change), int'(m_sc));
    chk("emergency_active", int'(emergency_active), int'(m_act));
    if (int'(state) != last_state) begin
      phase_log.push_back(int'(state));
      last_state = int'(state);
    end
  endtask

  // Periodic tick: one every fourth clock.
  task automatic pcycle(input bit em, input bit rns, input bit rew);
    cycle(cyc % 4 == 3, em, rns, rew);
    cyc++;
  endtask

  // Bounded wait for a phase (rem < 0 means any remaining value).
  task automatic run_until(input string tag, input int ph, input int rem, input bit em);
    int n;
    n = 0;
    while (!(int'(state) == ph && (rem < 0 || int'(remaining) == rem)) && n < 400) begin
      pcycle(em, 1'b0, 1'b0);
      n++;
    end
    chk(tag, int'(int'(state) == ph && (rem < 0 || int'(remaining) == rem)), 1);
  endtask

  task automatic run_log(input int len);
    int n;
    n = 0;
    while (phase_log.size() < len && n < 400) begin
      pcycle(1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, phase_log.size(), exp_log.size());
    for (int i = 0; i < phase_log.size() && i < exp_log.size(); i++)
      chk(tag, phase_log[i], exp_log[i]);
  endtask

  task automatic async_reset_and_check(input string tag);
    #2 resetn = 1'b0;
    #1;
    chk({tag, "_state"}, int'(state), 6);
    chk({tag, "_remaining"}, int'(remaining), R);
    chk({tag, "_state_change"}, int'(state_change), 0);
    chk({tag, "_emergency_active"}, int'(emergency_active), 0);
    m_reset();
    last_state = 6;
    phase_log.delete();
    @(negedge clock);
    resetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int prev;
    int n_ns;
    bit prev_em, t, em;

    dwell_tab = '{G, Y, R, L, G, Y, R, L};
    cyc = 0;

    // Reset values, seen without any clock edge.
    #3;
    async_reset_and_check("reset");

    // Plain ring, no left requests.
    run_log(6);
    exp_log = {0, 1, 2, 4, 5, 6};
    check_log("ring");

    // One-clock EW left pulse in phase 0: arrow once, skipped the next time round.
    run_until("wait_ph0", 0, -1, 1'b0);
    phase_log.delete();
    last_state = int'(state);
    pcycle(1'b0, 1'b0, 1'b1);
    run_log(10);
    exp_log = {1, 2, 3, 4, 5, 6, 0, 1, 2, 4};
    check_log("ew_left");

    // Emergency in EW green with two ticks left.
    run_until("wait_ph4", 4, 2, 1'b0);
    pcycle(1'b1, 1'b0, 1'b0);
    chk("em_to_yellow", int'(state), 5);
    chk("em_yellow_rem", int'(remaining), Y);
    run_until("em_drain", 6, -1, 1'b1);
    repeat (40) pcycle(1'b1, 1'b0, 1'b0);
    chk("em_hold_state", int'(state), 6);
    chk("em_hold_rem", int'(remaining), R);
    chk("em_hold_active", int'(emergency_active), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("em_release_active", int'(emergency_active), 0);
    phase_log.delete();
    last_state = int'(state);
    run_log(1);
    exp_log = {0};
    check_log("em_resume");

    // Emergency on the same edge as the final tick of NS green.
    run_until("wait_ph0_last", 0, 1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("em_tick_state", int'(state), 1);
    chk("em_tick_rem", int'(remaining), Y);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (30) pcycle(1'b0, 1'b0, 1'b0);

    // NS left request held: every exit from phase 6 takes the NS arrow.
    prev = int'(state);
    n_ns = 0;
    for (int i = 0; i < 300; i++) begin
      pcycle(1'b0, 1'b1, 1'b0);
      if (prev == 6 && int'(state) != 6) begin
        chk("ns_left_taken", int'(state), 7);
        n_ns++;
      end
      prev = int'(state);
    end
    chk("ns_left_seen", int'(n_ns >= 2), 1);
    repeat (8) pcycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of EW left, then the ring restarts.
    pcycle(1'b0, 1'b0, 1'b1);
    run_until("wait_ph3", 3, -1, 1'b0);
    @(negedge clock);
    tick = 1'b0; emergency = 1'b0; left_req_ns = 1'b0; left_req_ew = 1'b0;
    async_reset_and_check("mid_reset");
    run_log(6);
    exp_log = {0, 1, 2, 4, 5, 6};
    check_log("ring_after_reset");

    // Randomized traffic against the model.
    prev_em = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      t  = ($urandom_range(0, 3) == 0);
      em = prev_em ^ ($urandom_range(0, 39) == 0);
      if (em != prev_em) t = 1'b0;
      cycle(t, em, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      prev_em = em;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
